cal_eep_spi_slave: RTL

// SPI responder modelling the 64x8 calibration EEPROM on chip-select ss[2] (3'b100).
// It is the far end of the config master's EEPROM write (8'h08) and read (8'h09) commands.

---
 rtl/cal_eep_spi_slave.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cal_eep_spi_slave.sv
// rtl/cal_eep_spi_slave.sv - SPI responder for the 64x8 calibration EEPROM
// Frames are {op, addr, data}, MSB first; writes commit only when SS_n deasserts.
module cal_eep_spi_slave #(
   parameter int unsigned        ADDR_W   = 6,
   parameter int unsigned        DATA_W   = 8,
   parameter logic [DATA_W-1:0]  FILL_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic SCLK,
   input  logic MOSI,
   output logic MISO,
   output logic MISO_en,
   output logic wr_done,
   output logic rd_done,
   output logic frame_err
);

   localparam int unsigned HDR_W   = 2 + ADDR_W;
   localparam int unsigned FRAME_W = HDR_W + DATA_W;
   localparam int unsigned RX_W    = (HDR_W > DATA_W) ? HDR_W : DATA_W;
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
   localparam int          DEPTH   = 1 << ADDR_W;

   localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HDR_W);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_TAIL
   } state_t;

   // Synchronisers; the third SCLK and SS_n flops give edge detection.
   logic ss_s1_q, ss_s2_q, ss_s3_q;
   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic mosi_s1_q, mosi_s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
         ss_s3_q   <= 1'b1;
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         ss_s1_q   <= SS_n;
         ss_s2_q   <= ss_s1_q;
         ss_s3_q   <= ss_s2_q;
         sclk_s1_q <= SCLK;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         mosi_s1_q <= MOSI;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   logic ss_fall, ss_rise, sclk_rise, sclk_fall;
   assign ss_fall   =  ss_s3_q & ~ss_s2_q;
   assign ss_rise   = ~ss_s3_q &  ss_s2_q;
   assign sclk_rise =  sclk_s2_q & ~sclk_s3_q & ~ss_s2_q;
   assign sclk_fall = ~sclk_s2_q &  sclk_s3_q & ~ss_s2_q;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RX_W-1:0]     rx_q, rx_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [1:0]          op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ovl_q, ovl_d;
   logic                miso_q, miso_d;
   logic                wr_done_q, wr_done_d;
   logic                rd_done_q, rd_done_d;
   logic                frame_err_q, frame_err_d;

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                mem_we;
   logic [RX_W-1:0]     rx_shift;
   logic [CNT_W-1:0]    cnt_inc;
   logic                frame_ok;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      op_d        = op_q;
      addr_d      = addr_q;
      ovl_d       = ovl_q;
      miso_d      = miso_q;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;
      frame_err_d = 1'b0;
      mem_we      = 1'b0;
      rx_shift    = {rx_q[RX_W-2:0], mosi_s2_q};
      cnt_inc     = cnt_q + CNT_ONE;
      frame_ok    = (cnt_q == FRAME_CNT) && !ovl_q;

      if (state_q == S_IDLE) begin
         miso_d = 1'b0;
         if (ss_fall) begin
            cnt_d   = '0;
            rx_d    = '0;
            tx_d    = '0;
            ovl_d   = 1'b0;
            state_d = S_HDR;
         end
      end else if (ss_rise) begin
         // Frame end outranks any SCLK edge seen in the same cycle.
         state_d = S_IDLE;
         miso_d  = 1'b0;
         if (frame_ok && op_q == OP_WRITE) begin
            mem_we    = 1'b1;
            wr_done_d = 1'b1;
         end else if (frame_ok && op_q == OP_READ) begin
            rd_done_d = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end else if (sclk_rise) begin
         case (state_q)
            S_HDR: begin
               rx_d  = rx_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == HDR_CNT) begin
                  op_d    = rx_shift[HDR_W-1 -: 2];
                  addr_d  = rx_shift[ADDR_W-1:0];
                  if (rx_shift[HDR_W-1 -: 2] == OP_READ)
                     tx_d = mem_q[rx_shift[ADDR_W-1:0]];
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               rx_d  = rx_shift;
               cnt_d = cnt_inc;
               if (cnt_inc == FRAME_CNT)
                  state_d = S_TAIL;
            end
            default: ovl_d = 1'b1;
         endcase
      end else if (sclk_fall && state_q == S_DATA && op_q == OP_READ) begin
         miso_d = tx_q[DATA_W-1];
         tx_d   = {tx_q[DATA_W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         op_q        <= '0;
         addr_q      <= '0;
         ovl_q       <= 1'b0;
         miso_q      <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         ovl_q       <= ovl_d;
         miso_q      <= miso_d;
         wr_done_q   <= wr_done_d;
         rd_done_q   <= rd_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= FILL_VAL;
      end else if (mem_we) begin
         mem_q[addr_q] <= rx_q[DATA_W-1:0];
      end
   end

   assign MISO      = miso_q;
   assign MISO_en   = ~ss_s2_q;
   assign wr_done   = wr_done_q;
   assign rd_done   = rd_done_q;
   assign frame_err = frame_err_q;

endmodule
